// File: rtl/bcd_digit_counter_if.sv
// rtl/bcd_digit_counter_if.sv - control and display signal bundle for the BCD digit counter
interface bcd_digit_counter_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       btn;
    logic       W;
    logic       X;
    logic       Y;
    logic       Z;
    logic       tick;
    logic       carry;
    logic       running;

    modport master (
        output en, up, load, din, btn,
        input  W, X, Y, Z, tick, carry, running
    );

    modport slave (
        input  en, up, load, din, btn,
        output W, X, Y, Z, tick, carry, running
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single decimal digit counter with prescaler, load and debounced run/pause
module bcd_digit_counter #(
    parameter int DIV       = 12000000,
    parameter int DB_CYCLES = 120000
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_digit_counter_if.slave bus
);

    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);

    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic           btn_s0;
    logic           btn_s1;
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic           press;
    logic [0:0]     state;
    logic [PW-1:0]  pre;
    logic [3:0]     count;
    logic           tick_q;
    logic           carry_q;

    logic           advance;
    logic           expire;
    logic           wrap;
    logic [3:0]     step_val;
    logic [3:0]     load_val;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s0 <= 1'b0;
            btn_s1 <= 1'b0;
        end else begin
            btn_s0 <= bus.btn;
            btn_s1 <= btn_s0;
        end
    end

    // Accept a new button level after DB_CYCLES consecutive differing samples; a rising accept is a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_s1;
                db_cnt   <= '0;
                press    <= btn_s1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Run/pause state toggles once per accepted press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (press) begin
            state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // Next-count arithmetic and load saturation
    always_comb begin
        advance  = bus.en && (state == ST_RUN);
        expire   = advance && (pre == PRE_LAST);
        wrap     = bus.up ? (count == 4'd9) : (count == 4'd0);
        step_val = 4'd0;
        if (bus.up) begin
            step_val = (count == 4'd9) ? 4'd0 : count + 4'd1;
        end else begin
            step_val = (count == 4'd0) ? 4'd9 : count - 4'd1;
        end
        load_val = (bus.din > 4'd9) ? 4'd9 : bus.din;
    end

    // Prescaler: cleared by load, frozen when paused or disabled, wraps after DIV-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (bus.load) begin
            pre <= '0;
        end else if (advance) begin
            pre <= expire ? '0 : pre + 1'b1;
        end
    end

    // Digit register with registered tick and carry pulses; load overrides a coincident step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 4'd0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (bus.load) begin
            count   <= load_val;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= expire;
            carry_q <= expire && wrap;
            if (expire) begin
                count <= step_val;
            end
        end
    end

    assign bus.W       = count[0];
    assign bus.X       = count[1];
    assign bus.Y       = count[2];
    assign bus.Z       = count[3];
    assign bus.tick    = tick_q;
    assign bus.carry   = carry_q;
    assign bus.running = (state == ST_RUN);

endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb/tb_bcd_digit_counter.sv - scoreboard bench for bcd_digit_counter
module tb_bcd_digit_counter;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    bcd_digit_counter_if bus ();

    bcd_digit_counter #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int       m_cnt;
    int       m_pre;
    bit       m_run;
    bit       m_press;
    bit       m_tick;
    bit       m_carry;
    bit       m_level;
    bit       raw[$];
    bit       syn[$];
    logic [6:0] exp_q[$];

    function automatic logic [6:0] dut_vec();
        return {bus.running, bus.carry, bus.tick, bus.Z, bus.Y, bus.X, bus.W};
    endfunction

    task automatic model_step();
        bit sv;
        bit all_diff;
        bit new_press;
        if (!rst_n) begin
            m_cnt = 0; m_pre = 0; m_run = 1; m_press = 0;
            m_tick = 0; m_carry = 0; m_level = 0;
            raw.delete(); syn.delete();
        end else begin
            sv = (raw.size() >= 2) ? raw[raw.size()-2] : 1'b0;
            raw.push_back(bus.btn);
            if (raw.size() > 3) void'(raw.pop_front());
            syn.push_back(sv);
            if (syn.size() > DB) void'(syn.pop_front());
            all_diff = (syn.size() == DB);
            foreach (syn[i]) if (syn[i] == m_level) all_diff = 0;
            new_press = 0;
            if (all_diff) begin
                m_level   = ~m_level;
                new_press = m_level;
            end
            m_tick  = 0;
            m_carry = 0;
            if (bus.load) begin
                m_cnt = (bus.din > 9) ? 9 : int'(bus.din);
                m_pre = 0;
            end else if (bus.en && m_run) begin
                if (m_pre == DIV - 1) begin
                    m_pre  = 0;
                    m_tick = 1;
                    if (bus.up) begin
                        m_carry = (m_cnt == 9);
                        m_cnt   = (m_cnt + 1) % 10;
                    end else begin
                        m_carry = (m_cnt == 0);
                        m_cnt   = (m_cnt + 9) % 10;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            m_run   = m_run ^ m_press;
            m_press = new_press;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        exp_q.push_back({m_run, m_carry, m_tick, 4'(m_cnt)});
        ncyc++;
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    function automatic int dut_cnt();
        return int'({bus.Z, bus.Y, bus.X, bus.W});
    endfunction

    // monitor: compares every presented output against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            logic [6:0] g;
            e = exp_q.pop_front();
            g = dut_vec();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sb cycle %0d got run=%b carry=%b tick=%b cnt=%0d exp run=%b carry=%b tick=%b cnt=%0d",
                         ncyc, g[6], g[5], g[4], g[3:0], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic press_btn();
        bus.btn = 1'b1;
        repeat (10) cyc();
        bus.btn = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        int carries;
        int ticks;
        int held;
        int hold_left;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.up   = 1'b1;
        bus.load = 1'b0;
        bus.din  = 4'd0;
        bus.btn  = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("reset_cnt", dut_cnt(), 0);
        chk("reset_run", int'(bus.running), 1);
        chk("reset_tick", int'(bus.tick), 0);

        // count up 40 cycles
        bus.en = 1'b1;
        carries = 0; ticks = 0;
        repeat (40) begin
            cyc();
            carries += int'(bus.carry);
            ticks   += int'(bus.tick);
        end
        chk("up_ticks", ticks, 10);
        chk("up_carries", carries, 1);
        chk("up_wrap_cnt", dut_cnt(), 0);

        // one step down from 0
        bus.up = 1'b0;
        repeat (4) cyc();
        chk("down_cnt", dut_cnt(), 9);
        chk("down_carry", int'(bus.carry), 1);
        cyc();
        chk("down_carry_pulse", int'(bus.carry), 0);

        // load coinciding with prescaler expiry
        bus.up = 1'b1;
        for (int i = 0; i < 8 && m_pre != DIV - 1; i++) cyc();
        chk("pre_at_last", m_pre, DIV - 1);
        bus.load = 1'b1; bus.din = 4'd7;
        cyc();
        bus.load = 1'b0;
        chk("load_cnt", dut_cnt(), 7);
        chk("load_carry", int'(bus.carry), 0);
        chk("load_tick", int'(bus.tick), 0);
        bus.load = 1'b1; bus.din = 4'd12;
        cyc();
        bus.load = 1'b0;
        chk("load_sat", dut_cnt(), 9);

        // glitch then real presses
        bus.btn = 1'b1;
        cyc(); cyc();
        bus.btn = 1'b0;
        repeat (8) cyc();
        chk("glitch_run", int'(bus.running), 1);
        press_btn();
        chk("press_pause", int'(bus.running), 0);
        held = dut_cnt(); ticks = 0;
        repeat (12) begin cyc(); ticks += int'(bus.tick); end
        chk("pause_hold", dut_cnt(), held);
        chk("pause_ticks", ticks, 0);
        press_btn();
        chk("press_run", int'(bus.running), 1);

        // enable low
        bus.en = 1'b0;
        held = dut_cnt(); ticks = 0;
        repeat (20) begin cyc(); ticks += int'(bus.tick); end
        chk("en0_ticks", ticks, 0);
        chk("en0_hold", dut_cnt(), held);
        bus.en = 1'b1;
        ticks = 0;
        repeat (8) begin cyc(); ticks += int'(bus.tick); end
        chk("en1_ticks", ticks, 2);

        // reset while paused at 6
        press_btn();
        bus.load = 1'b1; bus.din = 4'd6;
        cyc();
        bus.load = 1'b0;
        chk("pause6_cnt", dut_cnt(), 6);
        chk("pause6_run", int'(bus.running), 0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_cnt", dut_cnt(), 0);
        chk("rst_run", int'(bus.running), 1);
        chk("rst_tick", int'({bus.tick, bus.carry}), 0);

        // randomized traffic
        hold_left = 0;
        repeat (2500) begin
            bus.en   = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) bus.up = ~bus.up;
            bus.load = ($urandom_range(31) == 0);
            bus.din  = 4'($urandom_range(15));
            if (hold_left == 0) begin
                bus.btn   = ~bus.btn;
                hold_left = $urandom_range(12, 1);
            end
            hold_left--;
            rst_n = ($urandom_range(499) != 0);
            cyc();
        end
        rst_n = 1'b1;

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
